// File: rtl/polar_msg_framer.sv
// Serial message framer for a length-8 polar code.
// Collects K message bits into infor_o and the matching golden u-vector.
module polar_msg_framer #(
    parameter int N = 8,
    parameter int K = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         bit_i,
    input  logic         bit_valid_i,
    output logic         bit_ready_o,
    input  logic         abort_i,
    output logic [0:K-1] infor_o,
    output logic [0:N-1] ref_u_o,
    output logic         frame_valid_o,
    input  logic         frame_ready_i,
    output logic [7:0]   frame_cnt_o
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        HOLD    = 2'd2
    } state_e;

    state_e       state_q, state_d;
    logic [2:0]   cnt_q, cnt_d;
    logic [0:K-1] infor_q, infor_d;
    logic [0:N-1] ref_u_q, ref_u_d;
    logic [7:0]   fcnt_q, fcnt_d;

    // Information set of the length-8 code: the K most reliable positions.
    function automatic int info_pos(int j);
        if (K == 4) begin
            return (j == 0) ? 3 : 4 + j;
        end
        return N - K + j;
    endfunction

    // Next-state: bit collection, abort, and frame hand-off
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        infor_d = infor_q;
        fcnt_d  = fcnt_q;
        unique case (state_q)
            IDLE, COLLECT: begin
                if (abort_i) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (bit_valid_i) begin
                    for (int j = 0; j < K; j++) begin
                        if (cnt_q == 3'(j)) begin
                            infor_d[j] = bit_i;
                        end
                    end
                    cnt_d   = cnt_q + 3'd1;
                    state_d = (cnt_d == 3'(K)) ? HOLD : COLLECT;
                end
            end
            HOLD: begin
                if (frame_ready_i) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    fcnt_d  = fcnt_q + 8'd1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Scatter the message onto its information positions; frozen bits stay 0
    always_comb begin
        ref_u_d = '0;
        for (int p = 0; p < N; p++) begin
            for (int j = 0; j < K; j++) begin
                if (info_pos(j) == p) begin
                    ref_u_d[p] = infor_d[j];
                end
            end
        end
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            infor_q <= '0;
            ref_u_q <= '0;
            fcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            infor_q <= infor_d;
            ref_u_q <= ref_u_d;
            fcnt_q  <= fcnt_d;
        end
    end

    assign bit_ready_o   = (state_q != HOLD);
    assign frame_valid_o = (state_q == HOLD);
    assign infor_o       = infor_q;
    assign ref_u_o       = ref_u_q;
    assign frame_cnt_o   = fcnt_q;

endmodule

// File: tb/tb_polar_msg_framer.sv
// Bench for polar_msg_framer: four instances (K=1..4) share one stimulus.
// A frame-level model is compared every cycle; directed literals pin it.
module tb_polar_msg_framer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n, bit_i, bv, ab, fr;

    logic       rdy1, rdy2, rdy3, rdy4;
    logic       fv1, fv2, fv3, fv4;
    logic [7:0] fc1, fc2, fc3, fc4;
    logic [0:0] inf1;
    logic [0:1] inf2;
    logic [0:2] inf3;
    logic [0:3] inf4;
    logic [0:7] ru1, ru2, ru3, ru4;

    polar_msg_framer #(.N(8), .K(1)) u1 (
        .clk(clk), .rst_n(rst_n), .bit_i(bit_i), .bit_valid_i(bv),
        .bit_ready_o(rdy1), .abort_i(ab), .infor_o(inf1), .ref_u_o(ru1),
        .frame_valid_o(fv1), .frame_ready_i(fr), .frame_cnt_o(fc1));
    polar_msg_framer #(.N(8), .K(2)) u2 (
        .clk(clk), .rst_n(rst_n), .bit_i(bit_i), .bit_valid_i(bv),
        .bit_ready_o(rdy2), .abort_i(ab), .infor_o(inf2), .ref_u_o(ru2),
        .frame_valid_o(fv2), .frame_ready_i(fr), .frame_cnt_o(fc2));
    polar_msg_framer #(.N(8), .K(3)) u3 (
        .clk(clk), .rst_n(rst_n), .bit_i(bit_i), .bit_valid_i(bv),
        .bit_ready_o(rdy3), .abort_i(ab), .infor_o(inf3), .ref_u_o(ru3),
        .frame_valid_o(fv3), .frame_ready_i(fr), .frame_cnt_o(fc3));
    polar_msg_framer #(.N(8), .K(4)) u4 (
        .clk(clk), .rst_n(rst_n), .bit_i(bit_i), .bit_valid_i(bv),
        .bit_ready_o(rdy4), .abort_i(ab), .infor_o(inf4), .ref_u_o(ru4),
        .frame_valid_o(fv4), .frame_ready_i(fr), .frame_cnt_o(fc4));

    logic       a_rdy [1:4];
    logic       a_fv  [1:4];
    logic [3:0] a_inf [1:4];
    logic [7:0] a_ru  [1:4];
    logic [7:0] a_fc  [1:4];

    assign a_rdy[1] = rdy1;
    assign a_rdy[2] = rdy2;
    assign a_rdy[3] = rdy3;
    assign a_rdy[4] = rdy4;
    assign a_fv[1]  = fv1;
    assign a_fv[2]  = fv2;
    assign a_fv[3]  = fv3;
    assign a_fv[4]  = fv4;
    assign a_inf[1] = {3'b000, inf1};
    assign a_inf[2] = {2'b00, inf2};
    assign a_inf[3] = {1'b0, inf3};
    assign a_inf[4] = inf4;
    assign a_ru[1]  = ru1;
    assign a_ru[2]  = ru2;
    assign a_ru[3]  = ru3;
    assign a_ru[4]  = ru4;
    assign a_fc[1]  = fc1;
    assign a_fc[2]  = fc2;
    assign a_fc[3]  = fc3;
    assign a_fc[4]  = fc4;

    int nchk = 0;
    int nerr = 0;

    task automatic chk(string nm, int k, logic [31:0] act, logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s K=%0d got %0h want %0h at %0t", nm, k, act, exp, $time);
        end
    endtask

    // Frame-level model: message buffer, fill count, holding flag, frames sent
    int  m_cnt  [1:4];
    bit  m_hold [1:4];
    bit  m_msg  [1:4][0:3];
    int  m_fc   [1:4];

    always @(posedge clk or negedge rst_n) begin
        for (int k = 1; k <= 4; k++) begin
            if (!rst_n) begin
                m_cnt[k]  <= 0;
                m_hold[k] <= 1'b0;
                m_fc[k]   <= 0;
                for (int j = 0; j < 4; j++) m_msg[k][j] <= 1'b0;
            end else if (m_hold[k]) begin
                if (fr) begin
                    m_hold[k] <= 1'b0;
                    m_cnt[k]  <= 0;
                    m_fc[k]   <= (m_fc[k] + 1) % 256;
                end
            end else if (ab) begin
                m_cnt[k] <= 0;
            end else if (bv) begin
                m_msg[k][m_cnt[k]] <= bit_i;
                m_cnt[k]  <= m_cnt[k] + 1;
                m_hold[k] <= (m_cnt[k] + 1 == k);
            end
        end
    end

    function automatic int ipos(int k, int j);
        case (k)
            1: return 7;
            2: return 6 + j;
            3: return 5 + j;
            default: begin
                case (j)
                    0: return 3;
                    1: return 5;
                    2: return 6;
                    default: return 7;
                endcase
            end
        endcase
    endfunction

    function automatic logic [3:0] exp_inf(int k);
        logic [3:0] v = '0;
        for (int j = 0; j < k; j++) v = {v[2:0], m_msg[k][j]};
        return v;
    endfunction

    function automatic logic [7:0] exp_ru(int k);
        logic [7:0] v = '0;
        for (int j = 0; j < k; j++) v[7 - ipos(k, j)] = m_msg[k][j];
        return v;
    endfunction

    // Every-cycle comparison of all instances against the model
    always @(negedge clk) begin
        if (rst_n) begin
            for (int k = 1; k <= 4; k++) begin
                chk("m_ready", k, a_rdy[k], !m_hold[k]);
                chk("m_valid", k, a_fv[k], m_hold[k]);
                chk("m_infor", k, a_inf[k], exp_inf(k));
                chk("m_ref_u", k, a_ru[k], exp_ru(k));
                chk("m_fcnt", k, a_fc[k], m_fc[k][7:0]);
            end
        end
    end

    task automatic cyc(logic v, logic b, logic a, logic f);
        bv = v;
        bit_i = b;
        ab = a;
        fr = f;
        @(negedge clk);
    endtask

    task automatic do_reset();
        bv = 1'b0;
        ab = 1'b0;
        fr = 1'b0;
        bit_i = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        bv = 1'b0;
        ab = 1'b0;
        fr = 1'b0;
        bit_i = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        chk("rst_ready", 4, rdy4, 1);
        chk("rst_valid", 4, fv4, 0);
        chk("rst_infor", 4, inf4, 0);
        chk("rst_ref_u", 4, ru4, 0);
        chk("rst_fcnt", 4, fc4, 0);

        // Continuous 1,0,1,1 with downstream always ready
        cyc(1, 1, 0, 1);
        cyc(1, 0, 0, 1);
        cyc(1, 1, 0, 1);
        cyc(1, 1, 0, 1);
        chk("k4_infor", 4, inf4, 4'b1011);
        chk("k4_ref_u", 4, ru4, 8'b00010011);
        chk("k4_valid", 4, fv4, 1);
        cyc(0, 0, 0, 1);
        chk("k4_valid_after", 4, fv4, 0);
        chk("k4_fcnt_after", 4, fc4, 1);

        // Back-pressure: HOLD ignores bits and abort
        do_reset();
        cyc(1, 1, 0, 0);
        cyc(1, 1, 0, 0);
        cyc(1, 0, 0, 0);
        cyc(1, 1, 0, 0);
        for (int i = 0; i < 5; i++) begin
            cyc(1, i[0], (i == 2), 0);
            chk("bp_ready", 4, rdy4, 0);
            chk("bp_valid", 4, fv4, 1);
            chk("bp_infor", 4, inf4, 4'b1101);
            chk("bp_ref_u", 4, ru4, 8'b00010101);
        end
        cyc(0, 0, 0, 1);
        chk("bp_release_valid", 4, fv4, 0);
        chk("bp_release_ready", 4, rdy4, 1);
        chk("bp_release_fcnt", 4, fc4, 1);

        // K=3: abort mid-frame with a valid bit present
        do_reset();
        cyc(1, 1, 0, 0);
        cyc(1, 1, 0, 0);
        cyc(1, 1, 1, 0);
        cyc(1, 0, 0, 0);
        cyc(1, 1, 0, 0);
        cyc(1, 0, 0, 0);
        chk("abort_infor", 3, inf3, 3'b010);
        chk("abort_ref_u", 3, ru3, 8'b00000010);
        chk("abort_valid", 3, fv3, 1);

        // K=2: asynchronous reset after one bit
        do_reset();
        cyc(1, 1, 0, 0);
        chk("pre_rst_ref_u", 2, ru2, 8'b00000010);
        #1 rst_n = 1'b0;
        #1;
        chk("async_infor", 2, inf2, 0);
        chk("async_ref_u", 2, ru2, 0);
        chk("async_valid", 2, fv2, 0);
        chk("async_ready", 2, rdy2, 1);
        chk("async_fcnt", 2, fc2, 0);
        #1 rst_n = 1'b1;
        cyc(1, 1, 0, 0);
        cyc(1, 1, 0, 0);
        chk("k2_infor", 2, inf2, 2'b11);
        chk("k2_ref_u", 2, ru2, 8'b00000011);
        chk("k2_valid", 2, fv2, 1);

        // K=1: 256 back-to-back frames, counter wraps
        do_reset();
        for (int i = 0; i < 512; i++) begin
            logic [9:0] iv;
            logic       b;
            iv = 10'(i);
            b = iv[1] ^ iv[3] ^ iv[6];
            cyc(1, b, 0, 1);
            if (iv[0] == 1'b0) begin
                chk("k1_ref_u", 1, ru1, {7'b0000000, b});
                chk("k1_valid", 1, fv1, 1);
            end else begin
                chk("k1_gap_valid", 1, fv1, 0);
            end
            if (i == 509) chk("k1_fcnt_255", 1, fc1, 8'd255);
        end
        chk("k1_fcnt_wrap", 1, fc1, 8'd0);

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

endmodule

// File: doc/polar_msg_framer.md
POLAR_MSG_FRAMER -- requirements
Module: polar_msg_framer

Interface
REQ-001 Parameter N, default 8, polar block length; only 8 is supported.
REQ-002 Parameter K, default 4, message length; legal range 1..4.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 bit_i  input  1  serial message bit.
REQ-006 bit_valid_i  input  1  bit_i is valid this cycle.
REQ-007 bit_ready_o  output  1  framer can accept a bit this cycle.
REQ-008 abort_i  input  1  synchronous discard of a partial frame.
REQ-009 infor_o  output  [0:K-1]  assembled message; drives the polar encoder's infor_i.
REQ-010 ref_u_o  output  [0:N-1]  golden u-vector (frozen positions 0, info bits placed), for comparing against decoder u_hat outputs.
REQ-011 frame_valid_o  output  1  infor_o and ref_u_o hold a complete frame.
REQ-012 frame_ready_i  input  1  downstream consumes the frame.
REQ-013 frame_cnt_o  output  8  count of frames delivered, wraps 255->0.

Function
REQ-014 A bit transfer SHALL occur on a rising edge with bit_valid_i=1 and bit_ready_o=1.
REQ-015 A frame transfer SHALL occur on a rising edge with frame_valid_o=1 and frame_ready_i=1.
REQ-016 FSM states SHALL be IDLE, COLLECT and HOLD.
- IDLE: bit_cnt=0.
- COLLECT: 0<bit_cnt<K.
- HOLD: frame complete.
REQ-017 bit_ready_o SHALL be 1 in IDLE and COLLECT, and 0 in HOLD.
REQ-018 The j-th accepted bit (j=0..K-1) SHALL be written to infor_o[j], in MSB-first order.
REQ-019 After a transfer, if the new bit_cnt is below K: IDLE->COLLECT. If it equals K: ->HOLD. When K=1, IDLE->HOLD directly.
REQ-020 frame_valid_o SHALL be 1 exactly in HOLD, asserted the cycle after the K-th bit transfer.
- Latency from the last bit to frame_valid_o: 1 cycle.
REQ-021 infor_o and ref_u_o SHALL be stable for the whole of HOLD.
REQ-022 A frame transfer in HOLD SHALL:
- move the FSM to IDLE;
- clear bit_cnt;
- increment frame_cnt_o.
No bit is accepted in that same cycle.
REQ-023 ref_u_o SHALL be all zeros except at these information positions, which receive infor_o in ascending order:
- K=1: {7}
- K=2: {6,7}
- K=3: {5,6,7}
- K=4: {3,5,6,7}
REQ-024 ref_u_o SHALL be registered and updated in the same cycle as infor_o.
REQ-025 abort_i=1 in IDLE or COLLECT SHALL force IDLE and bit_cnt=0, and SHALL suppress any bit transfer in that cycle.
REQ-026 abort_i SHALL be ignored in HOLD; a completed frame is never dropped.
REQ-027 frame_ready_i SHALL be ignored outside HOLD.
REQ-028 bit_valid_i in HOLD SHALL have no effect.

Reset
REQ-029 Asserting rst_n=0 SHALL immediately set all outputs and state as follows, including mid-frame and in HOLD:
- FSM=IDLE, bit_cnt=0;
- infor_o=0, ref_u_o=0;
- frame_valid_o=0, frame_cnt_o=0;
- bit_ready_o=1.
REQ-030 After rst_n deasserts, the first bit SHALL be accepted on the first rising edge with bit_valid_i=1.

Verification
REQ-031 K=4, continuous bits 1,0,1,1, frame_ready_i=1 -> next cycle:
- infor_o=1011, ref_u_o=00010011, frame_valid_o=1;
- one cycle later: frame_valid_o=0, frame_cnt_o=1.
REQ-032 K=4, frame complete with frame_ready_i=0 for 5 cycles while bit_valid_i=1 -> bit_ready_o=0 and outputs frozen. Raise frame_ready_i -> transfer, then IDLE.
REQ-033 K=3, bits 1,1 then abort_i=1 with bit_valid_i=1, then bits 0,1,0 -> infor_o=010, ref_u_o=00000010.
REQ-034 K=2, rst_n pulsed low after 1 bit -> all outputs zero at once. Then bits 1,1 -> infor_o=11, ref_u_o=00000011.
REQ-035 K=1, 256 frames back-to-back -> frame_cnt_o wraps to 0.
- Every frame: ref_u_o[7] equals bit_i, all other positions 0.
REQ-036 Loopback K=4 through encoder, BPSK and decoder, all 16 messages -> every decoder u_hat equals ref_u_o.
